// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage in front of decoder_control. Owns the PC, issues
//   in-order word fetches over a valid/ready request channel, queues the
//   in-order responses in a small {pc,inst} buffer and presents the buffer
//   head to decode. Honours the decode load-use stall and redirects from
//   branch/jalr (br_taken) and trap (trap_valid, higher priority).
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   imem_req_valid/ready/addr        fetch request channel (word address)
//   imem_rsp_valid/data              in-order responses, >=1 cycle after accept
//   br_taken/br_target               redirect from execute
//   trap_valid/trap_vector           trap redirect, wins over br_taken
//   stall_flag, ds_allowin           decode back-pressure
//   fs_to_ds_valid, pc_out, inst_out presented instruction (NOP_INST if none)
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        trap_valid,
  input  logic [31:0] trap_vector,
  input  logic        stall_flag,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out
);

  // Storage is sized for the largest legal DEPTH; only DEPTH slots are used.
  localparam int               SLOTS    = 4;
  localparam logic [2:0]       DEPTH_C  = 3'(DEPTH);
  localparam logic [1:0]       LAST_IDX = 2'(DEPTH - 1);

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
  endfunction

  // State
  logic [31:0] fetch_pc_reg;
  logic [31:0] last_pc_reg;
  logic [2:0]  inflight_reg;   // live (not-to-be-dropped) outstanding requests
  logic [7:0]  drop_cnt_reg;   // outstanding responses to discard
  logic [1:0]  pcq_wr_reg, pcq_rd_reg;
  logic [1:0]  ibuf_wr_reg, ibuf_rd_reg;
  logic [2:0]  ibuf_cnt_reg;

  logic [31:0] pcq_mem       [SLOTS];
  logic [31:0] ibuf_pc_mem   [SLOTS];
  logic [31:0] ibuf_inst_mem [SLOTS];

  // Combinational control
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        rsp_drop, rsp_live;
  logic        pop, accept;
  logic [2:0]  occupancy;
  logic [7:0]  outstanding, drop_cnt_next;
  logic [31:0] head_pc, head_inst;

  assign redirect    = trap_valid | br_taken;
  assign redirect_pc = trap_valid ? trap_vector : br_target;
  assign flush       = rst | redirect;

  assign rsp_drop = imem_rsp_valid && (drop_cnt_reg != 8'd0);
  assign rsp_live = imem_rsp_valid && (drop_cnt_reg == 8'd0);

  // Head is read asynchronously: decode sees the buffer head in the same cycle.
  assign head_pc   = ibuf_pc_mem[ibuf_rd_reg];
  assign head_inst = ibuf_inst_mem[ibuf_rd_reg];

  assign fs_to_ds_valid = !rst && !redirect && (ibuf_cnt_reg != 3'd0);
  assign pop            = fs_to_ds_valid && ds_allowin && !stall_flag;

  // A credit is one buffer slot that is neither occupied nor promised to a
  // live in-flight request. Dropped responses never reach the buffer, so
  // they do not hold credits; this lets the first post-redirect request go
  // out on the very next cycle.
  assign occupancy      = inflight_reg + ibuf_cnt_reg - {2'b00, pop};
  assign imem_req_valid = !rst && !redirect && (occupancy < DEPTH_C);
  assign accept         = imem_req_valid && imem_req_ready;
  assign imem_req_addr  = fetch_pc_reg;

  assign pc_out   = rst ? 32'd0 : (fs_to_ds_valid ? head_pc : last_pc_reg);
  assign inst_out = fs_to_ds_valid ? head_inst : NOP_INST;

  // On flush every request still outstanding after this cycle's response
  // becomes a response to discard.
  assign outstanding   = drop_cnt_reg + {5'd0, inflight_reg};
  assign drop_cnt_next = (imem_rsp_valid && (outstanding != 8'd0)) ?
                         outstanding - 8'd1 : outstanding;

  // Control state
  always_ff @(posedge clk) begin
    if (flush) begin
      fetch_pc_reg <= rst ? RESET_PC : redirect_pc;
      pcq_wr_reg   <= 2'd0;
      pcq_rd_reg   <= 2'd0;
      ibuf_wr_reg  <= 2'd0;
      ibuf_rd_reg  <= 2'd0;
      ibuf_cnt_reg <= 3'd0;
      inflight_reg <= 3'd0;
      drop_cnt_reg <= drop_cnt_next;
      if (rst) begin
        last_pc_reg <= 32'd0;
      end
    end else begin
      if (accept) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;   // wraps naturally at 2^32
        pcq_wr_reg   <= ptr_inc(pcq_wr_reg);
      end
      if (rsp_live) begin
        pcq_rd_reg  <= ptr_inc(pcq_rd_reg);
        ibuf_wr_reg <= ptr_inc(ibuf_wr_reg);
      end
      if (rsp_drop) begin
        drop_cnt_reg <= drop_cnt_reg - 8'd1;
      end
      if (pop) begin
        ibuf_rd_reg <= ptr_inc(ibuf_rd_reg);
      end
      if (fs_to_ds_valid) begin
        last_pc_reg <= head_pc;
      end
      inflight_reg <= inflight_reg + {2'b00, accept} - {2'b00, rsp_live};
      ibuf_cnt_reg <= ibuf_cnt_reg + {2'b00, rsp_live} - {2'b00, pop};
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      pcq_mem[pcq_wr_reg] <= fetch_pc_reg;
    end
    if (!flush && rsp_live) begin
      ibuf_pc_mem[ibuf_wr_reg]   <= pcq_mem[pcq_rd_reg];
      ibuf_inst_mem[ibuf_wr_reg] <= imem_rsp_data;
    end
  end

  // The credit rule must keep the buffer from ever overflowing.
  always_ff @(posedge clk) begin
    if (!flush) begin
      assert (!(rsp_live && (ibuf_cnt_reg == DEPTH_C) && !pop));
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        br_taken;
  logic [31:0] br_target;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        stall_flag;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [31:0] pc_out;
  logic [31:0] inst_out;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .br_taken(br_taken), .br_target(br_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .stall_flag(stall_flag), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .pc_out(pc_out), .inst_out(inst_out)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Instruction memory: in-order responses with configurable latency
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];
  int    last_due = 0;
  int    lat_min  = 1;
  int    lat_max  = 1;

  // Reference model: queues of outstanding PCs and buffered instructions
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        m_buf[$];
  logic [31:0] m_live[$];
  int          m_stale   = 0;
  logic [31:0] m_pc      = RESET_PC;
  logic [31:0] m_last_pc = 32'd0;

  // Outputs sampled in the last completed cycle
  logic        s_req_valid, s_valid;
  logic [31:0] s_req_addr, s_pc, s_inst;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: present memory response, sample and compare at negedge,
  // advance the model, then return just after the next rising edge.
  task automatic step();
    bit          e_valid, e_req, e_pop, redir;
    logic [31:0] e_pc, e_inst, lpc;
    int          lat, due;
    ent_t        e;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_valid     = fs_to_ds_valid;
    s_pc        = pc_out;
    s_inst      = inst_out;

    redir   = br_taken || trap_valid;
    e_valid = !rst && !redir && (m_buf.size() > 0);
    e_pc    = rst ? 32'd0 : (e_valid ? m_buf[0].pc : m_last_pc);
    e_inst  = e_valid ? m_buf[0].inst : NOP_INST;
    e_pop   = e_valid && ds_allowin && !stall_flag;
    e_req   = !rst && !redir && ((m_live.size() + m_buf.size() - (e_pop ? 1 : 0)) < DEPTH);

    chk("req_valid", 32'(s_req_valid), 32'(e_req));
    if (e_req) chk("req_addr", s_req_addr, m_pc);
    chk("fs_to_ds_valid", 32'(s_valid), 32'(e_valid));
    chk("pc_out", s_pc, e_pc);
    chk("inst_out", s_inst, e_inst);

    if (rst || redir) begin
      m_stale = m_stale + m_live.size() - (imem_rsp_valid ? 1 : 0);
      if (m_stale < 0) m_stale = 0;
      m_live.delete();
      m_buf.delete();
      m_pc = rst ? RESET_PC : (trap_valid ? trap_vector : br_target);
      if (rst) m_last_pc = 32'd0;
    end else begin
      if (e_valid) m_last_pc = m_buf[0].pc;
      if (e_pop) void'(m_buf.pop_front());
      if (imem_rsp_valid) begin
        if (m_stale > 0) begin
          m_stale--;
        end else if (m_live.size() > 0) begin
          lpc    = m_live.pop_front();
          e.pc   = lpc;
          e.inst = imem_rsp_data;
          m_buf.push_back(e);
        end
      end
      if (e_req && imem_req_ready) begin
        m_live.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end

    // The memory reacts to the real bus handshake
    if (s_req_valid && imem_req_ready) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{s_req_addr, due});
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_valid(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (s_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  // Directed vectors from reset release: 1-cycle memory, decode always
  // ready, with a 3-cycle stall in the middle.
  typedef struct {
    bit          ready;
    bit          stall;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vec[10];

  initial begin
    int r;
    vec[0] = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vec[1] = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    vec[2] = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    vec[3] = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
    vec[4] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
    vec[5] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
    vec[6] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
    vec[7] = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
    vec[8] = '{1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
    vec[9] = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10};

    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    br_taken = 1'b0; br_target = 32'd0; trap_valid = 1'b0; trap_vector = 32'd0;
    stall_flag = 1'b0; ds_allowin = 1'b1;
    @(posedge clk); #1;

    // Reset values
    repeat (3) step();
    chk("reset_req_valid", 32'(s_req_valid), 32'd0);
    chk("reset_fs_valid", 32'(s_valid), 32'd0);
    chk("reset_pc_out", s_pc, 32'd0);
    chk("reset_inst_out", s_inst, NOP_INST);
    rst = 1'b0;

    // Reset release, straight-line fetch and load-use stall
    for (int i = 0; i < 10; i++) begin
      imem_req_ready = vec[i].ready;
      stall_flag     = vec[i].stall;
      step();
      chk($sformatf("vec%0d_req_valid", i), 32'(s_req_valid), 32'(vec[i].exp_req));
      if (vec[i].exp_req) chk($sformatf("vec%0d_req_addr", i), s_req_addr, vec[i].exp_addr);
      chk($sformatf("vec%0d_fs_valid", i), 32'(s_valid), 32'(vec[i].exp_valid));
      chk($sformatf("vec%0d_pc_out", i), s_pc, vec[i].exp_pc);
      chk($sformatf("vec%0d_inst_out", i), s_inst,
          vec[i].exp_valid ? inst_of(vec[i].exp_pc) : NOP_INST);
    end
    stall_flag = 1'b0;

    // Memory not ready: pending address holds, then flow resumes
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ready_low_addr_hold", s_req_addr, 32'h1C);
    end
    imem_req_ready = 1'b1;
    step();
    chk("ready_high_req_valid", 32'(s_req_valid), 32'd1);
    chk("ready_high_addr", s_req_addr, 32'h1C);
    step();
    chk("ready_high_next_addr", s_req_addr, 32'h20);

    // Branch redirect with requests in flight
    lat_min = 3; lat_max = 3;
    repeat (6) step();
    br_taken = 1'b1; br_target = 32'h100;
    step();
    chk("br_cycle_no_req", 32'(s_req_valid), 32'd0);
    chk("br_cycle_no_valid", 32'(s_valid), 32'd0);
    br_taken = 1'b0;
    step();
    chk("br_next_req_valid", 32'(s_req_valid), 32'd1);
    chk("br_next_req_addr", s_req_addr, 32'h100);
    wait_valid(20, "br_first_valid_timeout");
    chk("br_first_pc", s_pc, 32'h100);
    chk("br_first_inst", s_inst, inst_of(32'h100));

    // Trap and branch together: trap wins
    trap_valid = 1'b1; trap_vector = 32'h80; br_taken = 1'b1; br_target = 32'h200;
    step();
    trap_valid = 1'b0; br_taken = 1'b0;
    step();
    chk("trap_next_req_addr", s_req_addr, 32'h80);
    chk("trap_next_req_valid", 32'(s_req_valid), 32'd1);
    wait_valid(20, "trap_first_valid_timeout");
    chk("trap_first_pc", s_pc, 32'h80);

    // PC wrap at the top of the address space
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b0;
    repeat (6) step();
    imem_req_ready = 1'b1;
    br_taken = 1'b1; br_target = 32'hFFFF_FFF8;
    step();
    br_taken = 1'b0;
    step();
    chk("wrap_addr0", s_req_addr, 32'hFFFF_FFF8);
    step();
    chk("wrap_addr1", s_req_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr2", s_req_addr, 32'h0000_0000);
    chk("wrap_pc0", s_pc, 32'hFFFF_FFF8);
    step();
    chk("wrap_pc1", s_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc2", s_pc, 32'h0000_0000);
    chk("wrap_pc2_valid", 32'(s_valid), 32'd1);

    // Reset with one request in flight whose response lands after reset
    lat_min = 3; lat_max = 3;
    imem_req_ready = 1'b0;
    repeat (6) step();
    imem_req_ready = 1'b1;
    step();
    chk("rst_inflight_accept", 32'(s_req_valid), 32'd1);
    imem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_req_ready = 1'b1;
    step();
    chk("rst_first_req_valid", 32'(s_req_valid), 32'd1);
    chk("rst_first_req_addr", s_req_addr, RESET_PC);
    wait_valid(20, "rst_first_valid_timeout");
    chk("rst_first_pc", s_pc, RESET_PC);
    chk("rst_first_inst", s_inst, inst_of(RESET_PC));

    // Randomized traffic against the model
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 2000; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      ds_allowin     = ($urandom_range(4, 0) != 0);
      stall_flag     = ($urandom_range(5, 0) == 0);
      r              = $urandom_range(99, 0);
      br_taken       = (r < 3) || (r == 5);
      trap_valid     = (r >= 3) && (r < 6);
      br_target      = $urandom & 32'hFFFF_FFFC;
      trap_vector    = $urandom & 32'hFFFF_FFFC;
      rst            = ($urandom_range(299, 0) == 0);
      step();
    end
    rst = 1'b0; br_taken = 1'b0; trap_valid = 1'b0; stall_flag = 1'b0;
    ds_allowin = 1'b1; imem_req_ready = 1'b1;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
